// File: rtl/lcar_scan_seq.sv
// lcar_scan_seq: LED-panel scan-line sequencer (shift, latch, blank per line).
// Optional macro LCAR_SCAN_FRAME_ALT_EN drives address bit 18 from frame_alt.
module lcar_scan_seq #(
  parameter int PIX_PER_LINE = 64,
  parameter int NUM_LINES    = 16,
  parameter int LE_CYC       = 2,
  parameter int BLANK_CYC    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        frame_alt,
  input  logic        fm_cycle_stp,
  input  logic        fm_rd_valid,
  output logic        fm_rd_cycle,
  output logic [18:0] fm_ov_rd_adrs,
  output logic        dclk_out,
  output logic        le_out,
  output logic        blank,
  output logic [3:0]  scan_line,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int PW = $clog2(PIX_PER_LINE + 1);
  localparam int PHMAX = (LE_CYC > BLANK_CYC) ? LE_CYC : BLANK_CYC;
  localparam int CW = $clog2(PHMAX + 1);

  localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_PER_LINE - 1);
  localparam logic [CW-1:0] LE_LAST   = CW'(LE_CYC - 1);
  localparam logic [CW-1:0] BLK_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [3:0]    LINE_LAST = 4'(NUM_LINES - 1);
  localparam logic [17:0]   PIX_MUL   = 18'(PIX_PER_LINE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_BLANK
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0] pix_q, pix_d;
  logic [3:0]    line_q, line_d;
  logic [CW-1:0] ph_q, ph_d;

  logic [18:0] adrs_q, adrs_d;
  logic        dclk_q, dclk_d;
  logic        le_q, le_d;
  logic        blank_q, blank_d;
  logic [3:0]  scan_q, scan_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

  logic        accept;
  logic        last_blank;
  logic        bank_d;
  logic [17:0] adr_lo_d;

  assign fm_rd_cycle = (state_q == S_SHIFT) & ~fm_cycle_stp;
  assign accept      = fm_rd_cycle & fm_rd_valid;
  assign last_blank  = (state_q == S_BLANK) & (ph_q == BLK_LAST)
                     & (line_q == LINE_LAST);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    ph_d    = ph_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_SHIFT;
          pix_d   = '0;
          line_d  = '0;
        end
      end
      S_SHIFT: begin
        if (accept) begin
          pix_d = pix_q + PW'(1);
          if (pix_q == PIX_LAST) begin
            state_d = S_LATCH;
            ph_d    = '0;
          end
        end
      end
      S_LATCH: begin
        if (ph_q == LE_LAST) begin
          state_d = S_BLANK;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + CW'(1);
        end
      end
      S_BLANK: begin
        if (ph_q == BLK_LAST) begin
          if (line_q == LINE_LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SHIFT;
            line_d  = line_q + 4'd1;
            pix_d   = '0;
          end
        end else begin
          ph_d = ph_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LCAR_SCAN_FRAME_ALT_EN
  logic alt_q, alt_d;

  always_comb begin
    alt_d = alt_q;
    if (state_q == S_IDLE && frame_start) alt_d = frame_alt;
  end

  always_ff @(posedge clk) begin
    if (rst) alt_q <= 1'b0;
    else     alt_q <= alt_d;
  end

  assign bank_d = alt_d;
`else
  logic unused_frame_alt;
  assign unused_frame_alt = frame_alt;
  assign bank_d = 1'b0;
`endif

  // Address tracks the next pixel, so it only moves after an accept.
  always_comb begin
    adr_lo_d = 18'(line_d) * PIX_MUL + 18'(pix_d);
    adrs_d   = {bank_d, adr_lo_d};
    dclk_d   = accept;
    le_d     = (state_q == S_LATCH);
    blank_d  = (state_q == S_IDLE) | (state_q == S_BLANK);
    busy_d   = (state_d != S_IDLE);
    done_d   = last_blank;
    ovr_d    = frame_start & (state_q != S_IDLE);
    scan_d   = scan_q;
    if (state_q == S_BLANK && ph_q == '0) scan_d = line_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      ph_q    <= '0;
      adrs_q  <= '0;
      dclk_q  <= 1'b0;
      le_q    <= 1'b0;
      blank_q <= 1'b1;
      scan_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      ph_q    <= ph_d;
      adrs_q  <= adrs_d;
      dclk_q  <= dclk_d;
      le_q    <= le_d;
      blank_q <= blank_d;
      scan_q  <= scan_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign fm_ov_rd_adrs = adrs_q;
  assign dclk_out      = dclk_q;
  assign le_out        = le_q;
  assign blank         = blank_q;
  assign scan_line     = scan_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_lcar_scan_seq.sv
// Scoreboard bench for lcar_scan_seq: directed frames, expected events queued
// by the driver and consumed by a negedge monitor.
module tb_lcar_scan_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        frame_alt;
  logic        fm_cycle_stp;
  logic        fm_rd_valid;
  logic        fm_rd_cycle;
  logic [18:0] fm_ov_rd_adrs;
  logic        dclk_out;
  logic        le_out;
  logic        blank;
  logic [3:0]  scan_line;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  lcar_scan_seq dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_alt    (frame_alt),
    .fm_cycle_stp (fm_cycle_stp),
    .fm_rd_valid  (fm_rd_valid),
    .fm_rd_cycle  (fm_rd_cycle),
    .fm_ov_rd_adrs(fm_ov_rd_adrs),
    .dclk_out     (dclk_out),
    .le_out       (le_out),
    .blank        (blank),
    .scan_line    (scan_line),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

`ifdef LCAR_SCAN_FRAME_ALT_EN
  localparam int BANK = 32'h40000;
`else
  localparam int BANK = 0;
`endif

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int addr_q[$];
  int le_q[$];
  int done_q[$];
  int ovr_q[$];
  int scan_c_q[$];
  int scan_v_q[$];
  int dclk_cnt = 0;
  int le_hi_cnt = 0;
  bit mon_en = 1'b0;

  logic        prev_req, prev_acc, prev_stp, prev_le, prev_blank;
  logic [18:0] prev_adr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, tcyc);
    end
  endtask

  always @(negedge clk) begin : mon
    logic acc;
    int   e;
    if (mon_en) begin
      acc = fm_rd_cycle & fm_rd_valid;
      if (acc) begin
        if (addr_q.size() == 0) chk("addr_extra", 1, 0);
        else begin
          e = addr_q.pop_front();
          chk("addr", 32'(fm_ov_rd_adrs), e);
        end
      end
      if (prev_req && !prev_acc) chk("addr_hold", 32'(fm_ov_rd_adrs), 32'(prev_adr));
      if (prev_stp && fm_cycle_stp) chk("stall_hold", 32'(fm_ov_rd_adrs), 32'(prev_adr));
      if (fm_cycle_stp) chk("stall_req", 32'(fm_rd_cycle), 0);
      if (dclk_out) dclk_cnt++;
      if (le_out) le_hi_cnt++;
      if (le_out && !prev_le) begin
        if (le_q.size() == 0) chk("le_extra", 1, 0);
        else chk("le_rise_cyc", tcyc, le_q.pop_front());
      end
      if (blank && !prev_blank) begin
        if (scan_c_q.size() == 0) chk("blank_extra", 1, 0);
        else begin
          chk("blank_rise_cyc", tcyc, scan_c_q.pop_front());
          chk("scan_line", 32'(scan_line), scan_v_q.pop_front());
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) chk("done_extra", 1, 0);
        else begin
          chk("done_cyc", tcyc, done_q.pop_front());
          chk("done_busy", 32'(busy), 0);
        end
      end
      if (overrun) begin
        if (ovr_q.size() == 0) chk("ovr_extra", 1, 0);
        else chk("ovr_cyc", tcyc, ovr_q.pop_front());
      end
      prev_req   = fm_rd_cycle;
      prev_acc   = acc;
      prev_stp   = fm_cycle_stp;
      prev_le    = le_out;
      prev_blank = blank;
      prev_adr   = fm_ov_rd_adrs;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      frame_start  = 1'b0;
      fm_rd_valid  = 1'b1;
      fm_cycle_stp = 1'b0;
      frame_alt    = tcyc[0];
    end
  endtask

  // tog: valid low on odd cycles 1..127; stl: 10-cycle stall in line 3;
  // ovr: extra frame_start at 500 and 1184; rst_at: reset cycle or -1.
  task automatic run_frame(input int len, input bit tog, input bit stl,
                           input bit ovr, input int rst_at);
    int t0;
    int add;
    int nacc;
    nacc = (rst_at < 0) ? 1024 : 260;
    step();
    t0 = tcyc;
    for (int i = 0; i < nacc; i++) addr_q.push_back(BANK + i);
    for (int l = 0; l < 16; l++) begin
      add = (tog ? 64 : 0) + ((stl && l >= 3) ? 10 : 0);
      if (rst_at < 0 || 66 + 74 * l + add < rst_at)
        le_q.push_back(t0 + 66 + 74 * l + add);
      if (rst_at < 0 || 68 + 74 * l + add < rst_at) begin
        scan_c_q.push_back(t0 + 68 + 74 * l + add);
        scan_v_q.push_back(l);
      end
    end
    if (rst_at < 0) begin
      done_q.push_back(t0 + 1185 + (tog ? 64 : 0) + (stl ? 10 : 0));
    end else begin
      scan_c_q.push_back(t0 + rst_at + 1);
      scan_v_q.push_back(0);
    end
    if (ovr) begin
      ovr_q.push_back(t0 + 501);
      ovr_q.push_back(t0 + 1185);
    end
    dclk_cnt  = 0;
    le_hi_cnt = 0;
    for (int r = 0; r < len; r++) begin
      if (r > 0) step();
      frame_start  = (r == 0) || (ovr && (r == 500 || r == 1184));
      frame_alt    = (r == 0) ? 1'b1 : r[0];
      fm_rd_valid  = !(tog && r >= 1 && r <= 128 && r[0]);
      fm_cycle_stp = stl && r >= 253 && r <= 262;
      rst          = (r == rst_at);
      if (r == 2) chk("busy_run", 32'(busy), 1);
      if (rst_at >= 0 && r == rst_at + 1) begin
        chk("rst_blank", 32'(blank), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_scan", 32'(scan_line), 0);
        chk("rst_rdcyc", 32'(fm_rd_cycle), 0);
      end
    end
    chk("dclk_count", dclk_cnt, (rst_at < 0) ? 1024 : 259);
    chk("le_cycles", le_hi_cnt, (rst_at < 0) ? 32 : 8);
  endtask

  initial begin
    rst          = 1'b1;
    frame_start  = 1'b0;
    frame_alt    = 1'b0;
    fm_cycle_stp = 1'b0;
    fm_rd_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_blank", 32'(blank), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_dclk", 32'(dclk_out), 0);
    chk("reset_le", 32'(le_out), 0);
    chk("reset_scan", 32'(scan_line), 0);
    chk("reset_done", 32'(frame_done), 0);
    chk("reset_ovr", 32'(overrun), 0);
    chk("reset_adrs", 32'(fm_ov_rd_adrs), 0);
    chk("reset_rdcyc", 32'(fm_rd_cycle), 0);
    prev_req   = 1'b0;
    prev_acc   = 1'b0;
    prev_stp   = 1'b0;
    prev_le    = 1'b0;
    prev_blank = 1'b1;
    prev_adr   = '0;
    mon_en     = 1'b1;
    idle(2);
    run_frame(1185, 1'b0, 1'b0, 1'b1, -1);
    run_frame(1249, 1'b1, 1'b0, 1'b0, -1);
    idle(5);
    run_frame(1195, 1'b0, 1'b1, 1'b0, -1);
    idle(3);
    run_frame(340, 1'b0, 1'b0, 1'b0, 300);
    run_frame(1185, 1'b0, 1'b0, 1'b0, -1);
    idle(4);
    chk("addr_left", addr_q.size(), 0);
    chk("le_left", le_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    chk("ovr_left", ovr_q.size(), 0);
    chk("scan_left", scan_c_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
